// File: rtl/regfile_ctrl_pkg.sv
// Shared types, instruction field positions and helpers for the regfile_ctrl
// multi-cycle initiator and its ALU.
package regfile_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SLL  = 4'd6,
    OP_SRL  = 4'd7,
    OP_ADDI = 4'd8
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    WB
  } state_t;

  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RS0_LSB = 6;
  localparam int unsigned RS1_LSB = 3;
  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned IMM_W   = 6;

  function automatic logic [15:0] sext6(input logic [5:0] imm);
    return {{10{imm[5]}}, imm};
  endfunction

  // Opcodes 9..15 are unsupported.
  function automatic logic op_legal(input logic [3:0] op);
    return op <= 4'(OP_ADDI);
  endfunction

endpackage

// File: rtl/alu16.sv
// Purely combinational 16-bit ALU for regfile_ctrl; unsupported opcodes yield 0.
module alu16
  import regfile_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [5:0]  imm,
  output logic [15:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLL:  y = a << b[3:0];
      OP_SRL:  y = a >> b[3:0];
      OP_ADDI: y = a + sext6(imm);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/regfile_ctrl.sv
// Multi-cycle instruction initiator for an 8x16 register file: IDLE/READ/EXEC/WB.
// Optional macro REGFILE_CTRL_R0_ZERO_EN makes register 0 read as zero and never written.
module regfile_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  input  logic [15:0]   instr,
  output logic          instr_ready,
  output logic [AW-1:0] rd0_addr,
  output logic [AW-1:0] rd1_addr,
  input  logic [DW-1:0] rd0_data,
  input  logic [DW-1:0] rd1_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          illegal
);

  state_t               state, state_next;
  logic [OP_W-1:0]      op_q;
  logic [AW-1:0]        rd_q;
  logic [IMM_W-1:0]     imm_q;
  logic [DW-1:0]        opa, opb;
  logic [DW-1:0]        alu_y;
  logic                 accept;
  logic                 legal;
  logic                 wr_ok;

  assign instr_ready = (state == IDLE) && !rst;
  assign accept      = instr_valid && instr_ready;
  assign legal       = op_legal(op_q);

`ifdef REGFILE_CTRL_R0_ZERO_EN
  assign wr_ok = legal && (op_q != 4'(OP_NOP)) && (rd_q != '0);
`else
  assign wr_ok = legal && (op_q != 4'(OP_NOP));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = READ;
      READ:    state_next = EXEC;
      EXEC:    state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Retirement strobes are set on the EXEC->WB edge so they are high exactly in WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      opa      <= '0;
      opb      <= '0;
      rd0_addr <= '0;
      rd1_addr <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
      result   <= '0;
      illegal  <= 1'b0;
    end else begin
      wr_en   <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q     <= instr[OP_LSB +: OP_W];
            rd_q     <= instr[RD_LSB +: AW];
            imm_q    <= instr[IMM_LSB +: IMM_W];
            rd0_addr <= instr[RS0_LSB +: AW];
            rd1_addr <= instr[RS1_LSB +: AW];
          end
        end
        READ: begin
`ifdef REGFILE_CTRL_R0_ZERO_EN
          opa <= (rd0_addr == '0) ? '0 : rd0_data;
          opb <= (rd1_addr == '0) ? '0 : rd1_data;
`else
          opa <= rd0_data;
          opb <= rd1_data;
`endif
        end
        EXEC: begin
          result  <= alu_y;
          wr_data <= alu_y;
          wr_addr <= rd_q;
          wr_en   <= wr_ok;
          done    <= 1'b1;
          illegal <= !legal;
        end
        default: ;
      endcase
    end
  end

  alu16 u_alu (
    .op  (op_q),
    .a   (opa),
    .b   (opb),
    .imm (imm_q),
    .y   (alu_y)
  );

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed self-checking bench for regfile_ctrl with a behavioural 8x16 register file.
module tb_regfile_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic [2:0]  rd0_addr, rd1_addr, wr_addr;
  logic [15:0] rd0_data, rd1_data, wr_data, result;
  logic        wr_en, done, illegal;

  logic        pre_en = 1'b0;
  logic [2:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;
  logic [15:0] mem [8];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  regfile_ctrl #(.DW(16), .AW(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .rd0_addr    (rd0_addr),
    .rd1_addr    (rd1_addr),
    .rd0_data    (rd0_data),
    .rd1_data    (rd1_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .done        (done),
    .result      (result),
    .illegal     (illegal)
  );

  assign rd0_data = mem[rd0_addr];
  assign rd1_data = mem[rd1_addr];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Issue one instruction and check its retirement cycle.
  task automatic run(input string tag, input logic [15:0] iw, input logic exp_we,
                     input logic [2:0] exp_wa, input logic [15:0] exp_res);
    int n;
    @(negedge clk);
    instr = iw;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(instr_ready), 32'd1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    n = 0;
    while (!done && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd2);
    check({tag, "_wr_en"}, 32'(wr_en), 32'(exp_we));
    if (exp_we) begin
      check({tag, "_wr_addr"}, 32'(wr_addr), 32'(exp_wa));
      check({tag, "_wr_data"}, 32'(wr_data), 32'(exp_res));
    end
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    check({tag, "_illegal"}, 32'(illegal), 32'd0);
    check({tag, "_busy"}, 32'(instr_ready), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_wr_pulse"}, 32'(wr_en), 32'd0);
  endtask

  initial begin
    int n;
    logic seen;

    // Reset state
    #2;
    check("rst_ready", 32'(instr_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst_ready", 32'(instr_ready), 32'd1);

    run("addi_r1", 16'h8205, 1'b1, 3'd1, 16'h0005);
    run("addi_r2", 16'h843D, 1'b1, 3'd2, 16'hFFFD);
    run("add_r3", 16'h1650, 1'b1, 3'd3, 16'h0002);
    run("sub_r4", 16'h2888, 1'b1, 3'd4, 16'hFFF8);
    run("nop", 16'h0000, 1'b0, 3'd0, 16'h0000);

    preload(3'd1, 16'h8001);
    preload(3'd2, 16'h0004);
    run("sll_r5", 16'h6A50, 1'b1, 3'd5, 16'h0010);
    run("srl_r6", 16'h7C50, 1'b1, 3'd6, 16'h0800);
    run("or_r7", 16'h4E50, 1'b1, 3'd7, 16'h8005);
    run("xor_r7", 16'h5E48, 1'b1, 3'd7, 16'h0000);
    // rd equal to a source: r1 = r1 + r1 uses pre-write value 0x8001
    run("add_self", 16'h1248, 1'b1, 3'd1, 16'h0002);

    // Illegal opcode with instr_valid held high and a queued instruction behind it
    @(negedge clk);
    instr = 16'hC000;
    instr_valid = 1'b1;
    check("ill_ready", 32'(instr_ready), 32'd1);
    @(posedge clk);
    #1 instr = 16'h8601;
    n = 0;
    while (!done && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ill_latency", 32'(n), 32'd2);
    check("ill_illegal", 32'(illegal), 32'd1);
    check("ill_wr_en", 32'(wr_en), 32'd0);
    check("ill_ready_wb", 32'(instr_ready), 32'd0);
    @(posedge clk);
    #1;
    check("ill_idle_ready", 32'(instr_ready), 32'd1);
    check("ill_illegal_pulse", 32'(illegal), 32'd0);
    @(posedge clk);
    #1;
    check("queued_taken", 32'(instr_ready), 32'd0);
    instr_valid = 1'b0;
    n = 0;
    while (!done && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("queued_latency", 32'(n), 32'd2);
    check("queued_wr_en", 32'(wr_en), 32'd1);
    check("queued_wr_addr", 32'(wr_addr), 32'd3);
    check("queued_wr_data", 32'(wr_data), 32'd1);
    check("queued_illegal", 32'(illegal), 32'd0);
    @(posedge clk);
    #1;

    // Reset asserted during EXEC aborts the instruction
    @(negedge clk);
    instr = 16'h1650;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_ready", 32'(instr_ready), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_wr_data", 32'(wr_data), 32'd0);
    check("abort_wr_addr", 32'(wr_addr), 32'd0);
    check("abort_rd0_addr", 32'(rd0_addr), 32'd0);
    check("abort_rd1_addr", 32'(rd1_addr), 32'd0);
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 if (done || wr_en) seen = 1'b1;
    end
    check("abort_ready_held", 32'(instr_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("abort_release_ready", 32'(instr_ready), 32'd1);
    repeat (5) begin
      @(posedge clk);
      #1 if (done || wr_en) seen = 1'b1;
    end
    check("abort_no_retire", 32'(seen), 32'd0);

    // ADDI r0,r0,7
`ifdef REGFILE_CTRL_R0_ZERO_EN
    run("addi_r0", 16'h8007, 1'b0, 3'd0, 16'h0007);
`else
    run("addi_r0", 16'h8007, 1'b1, 3'd0, 16'h0007);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_ctrl.md
Name: regfile_ctrl

Overview:
- Multi-cycle initiator that drives the 8x16 register-file port set: two read addresses, one write address/data, and a write enable.
- Accepts one 16-bit instruction at a time over a valid/ready handshake.
- Reads two source registers, executes one ALU operation, writes the result back, then reports completion.
- Sits between the instruction source (bench, or a later fetch unit) and the register file.

Parameters:
- DW, 16, datapath and register width.
- AW, 3, register address width (2**AW registers).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction present on instr.
- instr  in  16  instruction word.
- instr_ready  out  1  controller can accept an instruction.
- rd0_addr  out  AW  register-file read port 0 address (rs0).
- rd1_addr  out  AW  register-file read port 1 address (rs1).
- rd0_data  in  DW  register-file read data 0 (combinational read).
- rd1_data  in  DW  register-file read data 1 (combinational read).
- wr_en  out  1  register-file write enable.
- wr_addr  out  AW  register-file write address (rd).
- wr_data  out  DW  register-file write data.
- done  out  1  one-cycle pulse when an instruction retires.
- result  out  DW  ALU result; valid while done=1.
- illegal  out  1  pulses together with done for an unsupported opcode.

Behaviour:
- Instruction fields:
  - [15:12] opcode.
  - [11:9] rd.
  - [8:6] rs0.
  - [5:3] rs1.
  - [5:0] imm6, two's complement.
- Opcodes (all arithmetic modulo 2**DW, no carry or overflow output):
  - 0 NOP.
  - 1 ADD.
  - 2 SUB (rs0-rs1).
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 SLL (rs0 << rs1[3:0]).
  - 7 SRL (logical).
  - 8 ADDI (rs0 + sext(imm6)).
  - 9-15 illegal.
- FSM states and transitions:
  - IDLE: instr_ready=1. Handshake when instr_valid && instr_ready at a rising edge; latch instr, go to READ.
  - READ: rd0_addr/rd1_addr driven from latched rs0/rs1. At the end of the cycle, capture rd0_data/rd1_data into operand registers. Go to EXEC.
  - EXEC: ALU output registered into result. Go to WB.
  - WB: wr_en=1 for exactly this cycle unless the op is NOP or illegal. done=1; illegal=1 if the opcode is illegal. Go to IDLE.
- Timing:
  - Handshake at edge N gives wr_en/done high in the cycle after edge N+2.
  - Throughput is one instruction per 4 cycles; instr_ready is low in READ, EXEC and WB.
- Output behaviour:
  - rd0_addr, rd1_addr, wr_addr and wr_data are registered and hold their last values outside the states that use them.
  - result holds until the next WB.
- Reset (async, rst=1): state IDLE, latched instruction 0, wr_en=0, done=0, illegal=0, all address/data/result outputs 0. instr_ready=0 while rst=1.
- Reset asserted mid-instruction aborts it: no write, no done. The first handshake is possible in the first cycle after rst falls.
- rd equal to rs0 or rs1 is legal: reads use the pre-write values.
- instr_valid held high through WB: the next instruction is accepted only in IDLE, and nothing is dropped. instr may change while instr_ready=0.

Optional Feature:
- Macro: REGFILE_CTRL_R0_ZERO_EN.
- When defined:
  - Source operand from register 0 reads as 0 regardless of rd0_data/rd1_data.
  - WB with rd=0 keeps wr_en=0; done and result are unaffected.
- When undefined: register 0 is an ordinary register.

Decomposition:
- Package regfile_ctrl_pkg:
  - opcode_t enum (NOP..ADDI).
  - state_t enum (IDLE, READ, EXEC, WB).
  - Field bit-position localparams.
  - Function sext6.
- Sub-module alu16: purely combinational (op, a, b, imm → y), instantiated once. The FSM stays in regfile_ctrl.

Test Plan:
- Reset then ADDI r1,r0,5 (0x8205), regfile reset to zeros: wr_en pulses once with wr_addr=1, wr_data=0x0005; done high in the same cycle; exactly 3 cycles from handshake edge to WB cycle.
- After ADDI r1,r0,5 and ADDI r2,r0,-3 (0x843D), ADD r3,r1,r2 then SUB r4,r2,r1: wr_data=0x0002, then 0xFFF8 (wrap-around).
- r1=0x8001, SLL r5,r1,r2 with r2=4 → 0x0010; SRL r6,r1,r2 → 0x0800.
- Opcode 0xC with instr_valid held high continuously: done and illegal pulse, no wr_en; the following queued instruction is accepted exactly in the next IDLE cycle.
- Assert rst during EXEC of an ADD: no wr_en and no done ever appear for it; outputs return to 0 immediately (asynchronously), and instr_ready=0 until rst deasserts.
- With REGFILE_CTRL_R0_ZERO_EN defined: ADDI r0,r0,7 gives done=1, result=0x0007, wr_en=0. Without the macro: wr_en=1, wr_addr=0.
